// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types for the bit-serial adder.
// FSM encoding and counter sizing helper.
package serial_adder_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit-position counter width, never below one bit.
  function automatic int cnt_w(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// One-bit full adder used as the serial cell.
// Pure gate-level combinational logic.
module full_adder_cell (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_c
);

  assign o_sum = i_a ^ i_b ^ i_cin;
  assign o_c   = (i_a & i_b) | (i_b & i_cin) | (i_cin & i_a);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial ripple adder, LSB first.
// One full-adder cell plus a carry flop.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_s_sh;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;
  logic [CW-1:0]    r_cnt;

  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_s_next;

  full_adder_cell u_fa (
    .i_a   (r_a_sh[0]),
    .i_b   (r_b_sh[0]),
    .i_cin (r_carry),
    .o_sum (w_s),
    .o_c   (w_c)
  );

  // New sum bit enters at the MSB; completed word is LSB aligned.
  assign w_s_next = (r_s_sh >> 1)
                  | (WIDTH'(w_s) << (WIDTH - 1));

  // Control FSM with datapath shift and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_s_sh  <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a_sh  <= a_in;
            r_b_sh  <= b_in;
            r_carry <= cin_in;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_s_sh  <= w_s_next;
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_carry <= w_c;
          r_cnt   <= r_cnt + CW'(1);
          if (r_cnt == LAST) begin
            r_sum   <= w_s_next;
            r_cout  <= w_c;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a_sh  <= a_in;
            r_b_sh  <= b_in;
            r_carry <= cin_in;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign sum_out = r_sum;
  assign cout    = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl.
// Covers WIDTH=8 and WIDTH=1 instances.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic [7:0] a_in = '0;
  logic [7:0] b_in = '0;
  logic       cin_in = 1'b0;
  logic       busy, done, cout;
  logic [7:0] sum_out;

  logic       s1_start = 1'b0;
  logic [0:0] s1_a = '0;
  logic [0:0] s1_b = '0;
  logic       s1_cin = 1'b0;
  logic       s1_busy, s1_done, s1_cout;
  logic [0:0] s1_sum;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .cin_in  (cin_in),
    .busy    (busy),
    .done    (done),
    .sum_out (sum_out),
    .cout    (cout)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (s1_start),
    .a_in    (s1_a),
    .b_in    (s1_b),
    .cin_in  (s1_cin),
    .busy    (s1_busy),
    .done    (s1_done),
    .sum_out (s1_sum),
    .cout    (s1_cout)
  );

  typedef struct {
    logic [8:0] v;
    int         cyc;
  } exp_t;

  exp_t q8[$];
  exp_t q1[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  // WIDTH=8 monitor
  always @(negedge clk) begin
    if (rst_n && done) begin
      exp_t e;
      chk("done8_busy_excl", 32'(busy), 0);
      chk("done8_expected", 32'(q8.size() > 0), 1);
      if (q8.size() > 0) begin
        e = q8.pop_front();
        chk("sum8", {23'd0, cout, sum_out}, 32'(e.v));
        chk("lat8", cyc, e.cyc);
      end
    end
  end

  // WIDTH=1 monitor
  always @(negedge clk) begin
    if (rst_n && s1_done) begin
      exp_t e;
      chk("done1_busy_excl", 32'(s1_busy), 0);
      chk("done1_expected", 32'(q1.size() > 0), 1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("sum1", {30'd0, s1_cout, s1_sum}, 32'(e.v));
        chk("lat1", cyc, e.cyc);
      end
    end
  end

  task automatic wait_idle8();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || done) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n >= 40) chk("idle8_timeout", 32'(busy), 0);
  endtask

  task automatic add8(input logic [7:0] a,
                      input logic [7:0] b,
                      input logic c,
                      input bit expect_done);
    exp_t e;
    wait_idle8();
    a_in = a; b_in = b; cin_in = c; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.v = {1'b0, a} + {1'b0, b} + {8'd0, c};
    e.cyc = cyc + 8;
    if (expect_done) q8.push_back(e);
  endtask

  task automatic add1(input logic a, input logic b, input logic c);
    exp_t e;
    @(negedge clk);
    s1_a = a; s1_b = b; s1_cin = c; s1_start = 1'b1;
    @(posedge clk);
    #1;
    s1_start = 1'b0;
    e.v = {8'd0, a} + {8'd0, b} + {8'd0, c};
    e.cyc = cyc + 1;
    q1.push_back(e);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int n;
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_sum", 32'(sum_out), 0);
    chk("rst_cout", 32'(cout), 0);
    chk("rst1_sum", {30'd0, s1_cout, s1_sum}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // busy for exactly 8 cycles, then done
    add8(8'h3C, 8'h5A, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t1_busy_run", 32'(busy), 1);
    end
    @(negedge clk);
    chk("t1_busy_end", 32'(busy), 0);
    chk("t1_done", 32'(done), 1);

    add8(8'hFF, 8'h01, 1'b0, 1'b1);
    add8(8'hFF, 8'hFF, 1'b1, 1'b1);

    // start during RUN must be ignored
    add8(8'h10, 8'h20, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    a_in = 8'hAA; b_in = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle8();
    chk("t3_sum_held", 32'(sum_out), 32'h30);

    // async reset mid-RUN
    add8(8'h33, 8'h44, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_busy", 32'(busy), 0);
    chk("t4_done", 32'(done), 0);
    chk("t4_sum", 32'(sum_out), 0);
    chk("t4_cout", 32'(cout), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("t4_no_done", 32'(done), 0);
    add8(8'h01, 8'h01, 1'b0, 1'b1);

    // back-to-back through DONE
    wait_idle8();
    a_in = 8'h80; b_in = 8'h80; cin_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    e.v = 9'h100; e.cyc = cyc + 8;
    q8.push_back(e);
    a_in = 8'h0F; b_in = 8'h01;
    n = 0;
    @(negedge clk);
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t5_first_done", 32'(done), 1);
    @(posedge clk);
    #1;
    e.v = 9'h010; e.cyc = cyc + 8;
    q8.push_back(e);
    start = 1'b0;
    chk("t5_resume_busy", 32'(busy), 1);

    // WIDTH=1 instance
    add1(1'b1, 1'b1, 1'b1);
    add1(1'b1, 1'b0, 1'b0);
    add1(1'b0, 1'b0, 1'b0);
    add1(1'b0, 1'b1, 1'b1);

    // random sweep against a+b+cin
    for (int i = 0; i < 1000; i++) begin
      add8(8'($urandom_range(0, 255)),
           8'($urandom_range(0, 255)),
           1'($urandom_range(0, 1)), 1'b1);
    end

    n = 0;
    while ((q8.size() + q1.size()) > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("queues_drained", q8.size() + q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
Bit-serial ripple adder built around one full-adder cell. Loads two WIDTH-bit operands and a carry-in on a start request, then feeds the cell one bit pair per clock, LSB first, while a carry flip-flop closes the loop. The serialised sum is shifted into a result register. Sum, carry-out and a done pulse are presented to the downstream consumer.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 1..32.

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request; accepted only in IDLE or DONE
a_in  input  WIDTH  operand A; sampled on accepted start
b_in  input  WIDTH  operand B; sampled on accepted start
cin_in  input  1  carry-in; sampled on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; sum_out/cout valid
sum_out  output  WIDTH  registered sum; held until next completion
cout  output  1  registered carry-out; held with sum_out

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset: state=IDLE, busy=0, done=0, sum_out=0, cout=0. All internal registers clear: a_sh, b_sh, s_sh, carry and cnt.
- FSM states: IDLE, RUN, DONE.
- IDLE with start=1: load a_sh<=a_in, b_sh<=b_in, carry<=cin_in, cnt<=0, then go to RUN. With start=0, stay in IDLE.
- RUN, each edge:
  - The cell computes s and c from a_sh[0], b_sh[0] and carry.
  - s_sh<={s, s_sh[WIDTH-1:1]}; a_sh and b_sh shift right by one with 0 fill; carry<=c; cnt<=cnt+1.
  - When cnt==WIDTH-1: sum_out<={s, s_sh[WIDTH-1:1]}, cout<=c, go to DONE.
- DONE lasts exactly one cycle with done=1.
  - start=1 in DONE is accepted as in IDLE (back-to-back operation; done still pulses this cycle) and the next state is RUN.
  - Otherwise the next state is IDLE.
- Latency: start sampled at edge E0; RUN occupies edges E1..E(WIDTH); done is high in the cycle after E(WIDTH). Start-to-done is WIDTH+1 clocks. Throughput is one add per WIDTH+1 clocks.
- start during RUN is ignored; operands and progress are unaffected.
- busy=1 exactly in RUN. done and busy are never high together.
- Arithmetic: {cout,sum_out} = a_in + b_in + cin_in, modulo 2^(WIDTH+1); no overflow flag.
- cnt width is max(1,$clog2(WIDTH)). For WIDTH=1, RUN lasts one cycle (cnt==0 is terminal).
- Asynchronous reset mid-RUN: immediate return to IDLE; no done pulse; sum_out/cout cleared to 0.
- sum_out/cout change only on RUN→DONE and on reset.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and a CNT_W helper function.
- One sub-module, full_adder_cell: purely combinational (a,b,cin → sum,c), instantiated once inside serial_adder_ctrl. It is gate-level XOR/AND/OR, with sum=a^b^cin and c=ab|bc|ca.

Test Plan:
1. WIDTH=8; start with a_in=0x3C, b_in=0x5A, cin_in=0 → busy high for 8 cycles. done pulses on the 9th clock after start, with sum_out=0x96 and cout=0.
2. a_in=0xFF, b_in=0x01, cin_in=0 → sum_out=0x00, cout=1. Also a_in=0xFF, b_in=0xFF, cin_in=1 → sum_out=0xFF, cout=1.
3. Start 0x10+0x20, then pulse start with 0xAA+0x55 on RUN cycle 3 → second request ignored. Result is 0x30 with cout=0; done pulses once.
4. rst_n low for one cycle during RUN cycle 4 → busy drops immediately, sum_out=0, no done. Next start with 0x01+0x01 gives 0x02.
5. Back-to-back: hold start=1 with 0x80+0x80, cin_in=0, then 0x0F+0x01 → first done gives 0x00 with cout=1. RUN resumes the next cycle; second done gives 0x10 with cout=0, 9 clocks after the first.
6. WIDTH=1: 1+1, cin_in=1 → done 2 clocks after start, sum_out=1, cout=1. Random 1000-vector sweep at WIDTH=8 matches the reference model a+b+cin.
